// File: rtl/mod9_disp_pkg.sv
// Shared types and constants for the base-9 two-digit display driver.
// Digit modulus, refresh FSM state encoding and the seven-segment table live here.
package mod9_disp_pkg;

    typedef enum logic [1:0] {
        UNITS   = 2'd0,
        BLANK_T = 2'd1,
        TENS    = 2'd2,
        BLANK_U = 2'd3
    } disp_state_t;

    localparam int DIGIT_MOD = 9;

    // Active-high {g,f,e,d,c,b,a} patterns for digits 0..8
    localparam logic [6:0] SEG_TABLE [DIGIT_MOD] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F
    };

endpackage

// File: rtl/mod9_display_driver_seg7_enc.sv
// Combinational digit-to-segment encoder; any code outside 0..8 renders blank.
module seg7_enc
    import mod9_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        for (int i = 0; i < DIGIT_MOD; i++) begin
            if (digit == 4'(i)) begin
                seg = SEG_TABLE[i];
            end
        end
    end

endmodule

// File: rtl/mod9_display_driver.sv
// Two-digit base-9 display driver: extends an upstream mod-9 units counter with a
// tens digit and multiplexes both digits onto a shared seven-segment bus.
//
//   state   | meaning
//   UNITS   | units digit shown, an=01, held REFRESH_DIV cycles
//   BLANK_T | one blank cycle before switching to tens, an=00
//   TENS    | tens digit shown, an=10, held REFRESH_DIV cycles
//   BLANK_U | one blank cycle before switching to units, an=00
module mod9_display_driver
    import mod9_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count_in,
    input  logic       en,
    output logic       carry,
    output logic [3:0] tens,
    output logic       overflow,
    output logic       err,
    output logic [1:0] an,
    output logic [6:0] seg
);

    localparam logic [7:0] CNT_LAST  = 8'(REFRESH_DIV - 1);
    localparam logic [3:0] DIGIT_TOP = 4'(DIGIT_MOD - 1);

    disp_state_t state, state_nxt;
    logic [7:0]  refresh_cnt;
    logic [3:0]  units_q;
    logic [3:0]  prev_q;
    logic        prev_valid;
    logic        wrap;
    logic [3:0]  digit_sel;
    logic [6:0]  enc_seg;

    // A carry needs a real 8->0 step; a 0 after anything else is an upstream reset
    assign wrap = en && prev_valid && (prev_q == DIGIT_TOP) && (count_in == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            units_q    <= 4'd0;
            prev_q     <= 4'd0;
            prev_valid <= 1'b0;
            carry      <= 1'b0;
            overflow   <= 1'b0;
            tens       <= 4'd0;
            err        <= 1'b0;
        end else begin
            carry    <= wrap;
            overflow <= wrap && (tens == DIGIT_TOP);
            if (wrap) begin
                tens <= (tens == DIGIT_TOP) ? 4'd0 : tens + 4'd1;
            end
            if (en) begin
                units_q    <= count_in;
                prev_q     <= count_in;
                prev_valid <= 1'b1;
                if (count_in > DIGIT_TOP) begin
                    err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNITS:   if (refresh_cnt == CNT_LAST) state_nxt = BLANK_T;
            BLANK_T: state_nxt = TENS;
            TENS:    if (refresh_cnt == CNT_LAST) state_nxt = BLANK_U;
            BLANK_U: state_nxt = UNITS;
            default: state_nxt = UNITS;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= UNITS;
            refresh_cnt <= 8'd0;
        end else begin
            state       <= state_nxt;
            refresh_cnt <= (state_nxt != state) ? 8'd0 : refresh_cnt + 8'd1;
        end
    end

    always_comb begin
        an = 2'b00;
        case (state)
            UNITS:   an = 2'b01;
            TENS:    an = 2'b10;
            default: an = 2'b00;
        endcase
    end

    assign digit_sel = (state == TENS) ? tens : units_q;

    seg7_enc u_seg7_enc (
        .digit (digit_sel),
        .seg   (enc_seg)
    );

    assign seg = (state == UNITS || state == TENS) ? enc_seg : 7'h00;

endmodule

// File: doc/mod9_display_driver.md
MOD9_DISPLAY_DRIVER -- requirements
Module: mod9_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 4, giving the cycles each digit is shown per refresh phase (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port count_in, input, 4, the units digit from the upstream mod-9 counter (legal 0..8).
REQ-005 SHALL have port en, input, 1, the sample enable; count_in is captured only on edges where en=1.
REQ-006 SHALL have port carry, output, 1, a one-cycle pulse on each detected units wrap 8->0.
REQ-007 SHALL have port tens, output, 4, the high base-9 digit (0..8).
REQ-008 SHALL have port overflow, output, 1, a one-cycle pulse when tens wraps 8->0.
REQ-009 SHALL have port err, output, 1, a sticky flag set when count_in>8 is sampled.
REQ-010 SHALL have port an, output, 2, the one-hot digit select: 01=units, 10=tens, 00=blank.
REQ-011 SHALL have port seg, output, 7, active-high segments {g,f,e,d,c,b,a} for the selected digit.

Function
REQ-012 SHALL capture count_in into units_q and prev_q on every edge with en=1, and SHALL set prev_valid=1 on the first such edge.
REQ-013 SHALL register carry=1 for exactly one cycle on the edge where en=1, prev_valid=1, prev_q==8 and count_in==0; otherwise carry=0.
REQ-014 SHALL increment tens on the same edge that sets carry, wrapping 8->0, and on that wrap SHALL pulse overflow in the same cycle as carry.
REQ-015 SHALL NOT produce carry for a 0 arriving from any prev_q other than 8, including an upstream sync reset.
REQ-016 SHALL treat en=0 as a freeze: no sampling, no carry, tens held; display refresh continues.
REQ-017 SHALL set err on any sampled count_in in 9..15, SHALL still capture that value into units_q and prev_q, and SHALL clear err only on reset.
REQ-018 SHALL run a refresh FSM with four states: UNITS, BLANK_T, TENS, BLANK_U.
REQ-019 SHALL hold UNITS and TENS for REFRESH_DIV cycles each, timed by a refresh counter that clears on every state change.
REQ-020 SHALL hold BLANK_T and BLANK_U for exactly 1 cycle each.
REQ-021 SHALL follow the transition order UNITS->BLANK_T->TENS->BLANK_U->UNITS.
REQ-022 SHALL decode an from the state register: 01 in UNITS, 10 in TENS, 00 in both blank states.
REQ-023 SHALL decode seg from the state register and the digit registers, with seg=0 in the blank states.
REQ-024 SHALL encode digits as 0:0x3F 1:0x06 2:0x5B 3:0x4F 4:0x66 5:0x6D 6:0x7D 7:0x07 8:0x7F, and any value 9..15 as 0x00.
REQ-025 SHALL let the displayed units value change mid-phase (the next cycle after capture) without restarting the refresh counter.

Reset
REQ-026 SHALL on reset low immediately force tens=0, carry=0, overflow=0, err=0, units_q=0, prev_q=0, prev_valid=0, refresh counter=0 and state=UNITS, giving an=01 and seg=0x3F.
REQ-027 SHALL let reset asserted mid-operation (any state or refresh count) override all other activity asynchronously, and SHALL resume in UNITS on the first edge after release.

Structure
REQ-028 SHALL take the FSM state typedef, the digit modulus 9 and the seven-segment constant table from shared package mod9_disp_pkg.
REQ-029 SHALL implement digit-to-segment decoding in one combinational sub-module, seg7_enc (4-bit in, 7-bit out), instantiated once on the mux output.

Verification
REQ-030 SHALL cover: reset low with count_in=5 -> an=01, seg=0x3F, tens=0, carry=0, err=0, all immediately.
REQ-031 SHALL cover: en=1, count_in 0,1,...,8,0 on consecutive cycles -> exactly one carry pulse, in the cycle after the 0 is sampled; tens=1.
REQ-032 SHALL cover: 81 consecutive samples 0..8 repeated, then a 0 -> tens reaches 8, the ninth wrap pulses carry and overflow together, and tens=0.
REQ-033 SHALL cover: one sample of count_in=11 -> err=1 and held, seg=0x00 during UNITS; err stays set after legal counts and clears only on reset.
REQ-034 SHALL cover: REFRESH_DIV=4, tens=3, units=5 -> an = 01 x4, 00 x1, 10 x4, 00 x1, repeating, with seg=0x6D in UNITS and 0x4F in TENS.
REQ-035 SHALL cover: prev_q=8 then en=0 while count_in=0 -> no carry; then reset pulsed low during TENS -> an=01 asynchronously.
